// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path.
//   OSR                 : oversampling ratio (ticks per bit).
//   byte_state_t        : byte receiver FSM encoding.
//   calc_osr_div        : Clk cycles per oversampling tick, rounded to nearest.
//   calc_timeout_cycles : inter-byte gap limit in Clk cycles.
package uart_pkg;

  localparam int OSR = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } byte_state_t;

  function automatic int calc_osr_div(input int clk_freq, input int baud);
    return (clk_freq + (baud * OSR) / 2) / (baud * OSR);
  endfunction

  function automatic int calc_timeout_cycles(input int clk_freq, input int baud,
                                             input int timeout_bits);
    return timeout_bits * OSR * calc_osr_div(clk_freq, baud);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//   8N1 byte receiver with 16x oversampling and 3-sample majority vote.
//   Ports:
//     Clk, Reset_n     : clock, asynchronous active-low reset
//     uart_rx          : serial line, idle high, asynchronous to Clk
//     byte_data[7:0]   : received byte, valid while byte_done is high
//     byte_done        : one-cycle pulse, stop bit read as 1
//     byte_err         : one-cycle pulse, stop bit read as 0
//     busy             : high from start detection until the FSM is back in IDLE
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       byte_err,
  output logic       busy
);

  localparam int OSR_DIV = calc_osr_div(CLK_FREQ, BAUD);
  localparam int DIV_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  byte_state_t      state, state_nxt;
  logic             rx_p0, rx_p1, rx_p2;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       samp;
  logic [7:0]       shreg;
  logic             tick, start_edge, mid_bit, end_bit, bit_val;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2 is only the edge-detect history
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Ticks are numbered 1..16 within a bit; tick_cnt holds ticks already seen,
  // so tick_cnt==8 on a tick is tick 9, where the third vote sample arrives.
  assign start_edge = (state == ST_IDLE) && rx_p2 && !rx_p1;
  assign tick       = (state != ST_IDLE) && (div_cnt == DIV_W'(OSR_DIV - 1));
  assign mid_bit    = tick && (tick_cnt == 4'd8);
  assign end_bit    = tick && (tick_cnt == 4'd15);
  assign bit_val    = maj3({samp, rx_p1});
  assign busy       = (state != ST_IDLE) || start_edge;
  assign byte_data  = shreg;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_edge) state_nxt = ST_START;
      ST_START: begin
        if (mid_bit && bit_val) state_nxt = ST_IDLE;
        else if (end_bit)       state_nxt = ST_DATA;
      end
      ST_DATA:  if (end_bit && (bit_idx == 3'd7)) state_nxt = ST_STOP;
      ST_STOP:  if (mid_bit) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Bit timing, voting and shift register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      samp      <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      byte_err  <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        // Divider phase restarts at each start edge
        div_cnt  <= '0;
        tick_cnt <= '0;
        bit_idx  <= '0;
      end else begin
        if (tick) begin
          div_cnt  <= '0;
          tick_cnt <= tick_cnt + 4'd1;
        end else begin
          div_cnt  <= div_cnt + DIV_W'(1);
        end
        if (tick && ((tick_cnt == 4'd6) || (tick_cnt == 4'd7)))
          samp <= {samp[0], rx_p1};
        if ((state == ST_DATA) && mid_bit)
          shreg <= {bit_val, shreg[7:1]};
        if ((state == ST_DATA) && end_bit)
          bit_idx <= bit_idx + 3'd1;
      end
      byte_done <= (state == ST_STOP) && mid_bit && bit_val;
      byte_err  <= (state == ST_STOP) && mid_bit && !bit_val;
    end
  end

endmodule

// File: rtl/uart_rx_data40.sv
// uart_rx_data40
//   Assembles five UART bytes into a 40-bit word, byte 0 in Data40[7:0].
//   A lost byte is recovered by an inter-byte gap timer; a framing error
//   drops the partial packet.
//   Ports:
//     Clk, Reset_n : clock, asynchronous active-low reset
//     uart_rx      : serial line, idle high
//     Data40       : last complete packet, updated only with Rx_Done
//     Rx_Done      : one-cycle pulse, Data40 just updated
//     Frame_Err    : one-cycle pulse, stop bit was 0, partial packet dropped
//     Timeout      : one-cycle pulse, partial packet dropped on gap expiry
module uart_rx_data40
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        uart_rx,
  output logic [39:0] Data40,
  output logic        Rx_Done,
  output logic        Frame_Err,
  output logic        Timeout
);

  localparam int TO_CYC = calc_timeout_cycles(CLK_FREQ, BAUD, TIMEOUT_BITS);
  localparam int TO_W   = $clog2(TO_CYC + 1);

  logic [7:0]      byte_data;
  logic            byte_done, byte_err, busy;
  logic [2:0]      cnt, cnt_nxt;
  logic [31:0]     sr;
  logic [TO_W-1:0] gap_cnt;
  logic            gap_exp;
  logic            done_nxt, ferr_nxt, to_nxt;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte_rx (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .uart_rx   (uart_rx),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .byte_err  (byte_err),
    .busy      (busy)
  );

  // busy already includes the start-detection cycle, so a start always beats
  // an expiry landing on the same edge.
  assign gap_exp = (cnt != 3'd0) && !busy && (gap_cnt == TO_W'(TO_CYC - 1));

  always_comb begin
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    ferr_nxt = 1'b0;
    to_nxt   = 1'b0;
    if (byte_done) begin
      if (cnt == 3'd4) begin
        cnt_nxt  = 3'd0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt  = cnt + 3'd1;
      end
    end else if (byte_err) begin
      cnt_nxt  = 3'd0;
      ferr_nxt = 1'b1;
    end else if (gap_exp) begin
      cnt_nxt  = 3'd0;
      to_nxt   = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= 3'd0;
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      Rx_Done   <= done_nxt;
      Frame_Err <= ferr_nxt;
      Timeout   <= to_nxt;
    end
  end

  // Byte slots; stale slots from a dropped packet are always overwritten
  // before the next completion.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr     <= '0;
      Data40 <= '0;
    end else if (byte_done) begin
      case (cnt)
        3'd0:    sr[7:0]   <= byte_data;
        3'd1:    sr[15:8]  <= byte_data;
        3'd2:    sr[23:16] <= byte_data;
        3'd3:    sr[31:24] <= byte_data;
        3'd4:    Data40    <= {byte_data, sr};
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      gap_cnt <= '0;
    else if (busy || (cnt == 3'd0) || gap_exp)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + TO_W'(1);
  end

endmodule

// File: tb/tb_uart_rx_data40.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_data40. The line rate is 625 kbaud on a 50 MHz
// clock (divider exactly 5, 80 Clk per bit) so the whole run stays short;
// the bit-level behaviour is identical to 115200 baud with divider 27.
module tb_uart_rx_data40;

  localparam int  CLK_FREQ = 50_000_000;
  localparam int  TB_BAUD  = 625_000;
  localparam real BIT_NS   = 1.0e9 / 625_000.0;

  logic        Clk     = 1'b0;
  logic        Reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [39:0] Data40;
  logic        Rx_Done, Frame_Err, Timeout;

  int n_total = 0;
  int n_bad   = 0;
  int n_done = 0, n_ferr = 0, n_to = 0, n_overlap = 0, n_d40_chg = 0;
  int cyc = 0, to_cyc = 0, t_end = 0;
  logic [39:0] words[$];
  logic [39:0] d40_prev = '0;
  logic        rst_prev = 1'b0;

  always #10 Clk = ~Clk;

  uart_rx_data40 #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (TB_BAUD),
    .TIMEOUT_BITS (20)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .uart_rx   (uart_rx),
    .Data40    (Data40),
    .Rx_Done   (Rx_Done),
    .Frame_Err (Frame_Err),
    .Timeout   (Timeout)
  );

  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (Rx_Done === 1'b1) begin
      n_done = n_done + 1;
      words.push_back(Data40);
    end
    if (Frame_Err === 1'b1) n_ferr = n_ferr + 1;
    if (Timeout === 1'b1) begin
      n_to   = n_to + 1;
      to_cyc = cyc;
    end
    if ((int'(Rx_Done) + int'(Frame_Err) + int'(Timeout)) > 1) n_overlap = n_overlap + 1;
    if (Reset_n && rst_prev && (Rx_Done !== 1'b1) && (Data40 !== d40_prev))
      n_d40_chg = n_d40_chg + 1;
    d40_prev = Data40;
    rst_prev = Reset_n;
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    n_done = 0;
    n_ferr = 0;
    n_to   = 0;
    words.delete();
  endtask

  function automatic logic [39:0] word_at(input int i);
    if (i < words.size()) return words[i];
    return 40'hx;
  endfunction

  task automatic idle(input real bits);
    uart_rx = 1'b1;
    #(bits * BIT_NS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bns);
    uart_rx = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(bns);
    end
    uart_rx = stop_bit;
    #(bns);
    uart_rx = 1'b1;
  endtask

  task automatic send_pkt(input logic [39:0] w, input real bns);
    for (int i = 0; i < 5; i++) send_byte(w[8*i +: 8], 1'b1, bns);
  endtask

  initial begin
    // Reset values
    #105;
    chk("rst_data40", Data40, 40'h0);
    chk("rst_done", {39'h0, Rx_Done}, 40'h0);
    chk("rst_ferr", {39'h0, Frame_Err}, 40'h0);
    chk("rst_to", {39'h0, Timeout}, 40'h0);
    #100 Reset_n = 1'b1;
    idle(4);

    // Back-to-back packet
    clr_mon();
    send_pkt(40'h5544332211, BIT_NS);
    idle(2);
    chk("s1_done", 40'(n_done), 40'd1);
    chk("s1_word", word_at(0), 40'h5544332211);
    chk("s1_data40", Data40, 40'h5544332211);
    chk("s1_ferr", 40'(n_ferr), 40'd0);
    chk("s1_to", 40'(n_to), 40'd0);

    // Lost bytes recovered by gap timeout
    clr_mon();
    send_byte(8'hAA, 1'b1, BIT_NS);
    send_byte(8'hBB, 1'b1, BIT_NS);
    send_byte(8'hCC, 1'b1, BIT_NS);
    t_end = cyc;
    idle(25);
    chk("s2_to", 40'(n_to), 40'd1);
    chk("s2_to_lat", {39'h0, ((to_cyc - t_end) >= 1550) && ((to_cyc - t_end) <= 1590)}, 40'd1);
    chk("s2_nodone", 40'(n_done), 40'd0);
    send_pkt(40'h0504030201, BIT_NS);
    idle(2);
    chk("s2_done", 40'(n_done), 40'd1);
    chk("s2_word", word_at(0), 40'h0504030201);
    chk("s2_ferr", 40'(n_ferr), 40'd0);

    // Framing error drops the partial packet
    clr_mon();
    send_byte(8'h12, 1'b1, BIT_NS);
    send_byte(8'h34, 1'b1, BIT_NS);
    send_byte(8'h56, 1'b0, BIT_NS);
    idle(2);
    chk("s3_ferr", 40'(n_ferr), 40'd1);
    chk("s3_keep", Data40, 40'h0504030201);
    chk("s3_nodone", 40'(n_done), 40'd0);
    send_pkt(40'h0504030201, BIT_NS);
    idle(2);
    chk("s3_done", 40'(n_done), 40'd1);
    chk("s3_word", word_at(0), 40'h0504030201);
    chk("s3_to", 40'(n_to), 40'd0);
    chk("s3_ferr_total", 40'(n_ferr), 40'd1);

    // Short low glitch is a false start
    clr_mon();
    uart_rx = 1'b0;
    #(BIT_NS * 4.0 / 16.0);
    idle(3);
    chk("s4_glitch", 40'(n_done + n_ferr + n_to), 40'd0);
    send_pkt(40'hDEADBEEF00, BIT_NS);
    idle(2);
    chk("s4_done", 40'(n_done), 40'd1);
    chk("s4_word", Data40, 40'hDEADBEEF00);
    chk("s4_errs", 40'(n_ferr + n_to), 40'd0);

    // Reset in the middle of byte 2
    clr_mon();
    send_byte(8'h0A, 1'b1, BIT_NS);
    send_byte(8'h0B, 1'b1, BIT_NS);
    uart_rx = 1'b0;
    #(BIT_NS);
    uart_rx = 1'b0;
    #(BIT_NS);
    uart_rx = 1'b1;
    #(BIT_NS * 1.5);
    Reset_n = 1'b0;
    #205;
    chk("s5_rst_data40", Data40, 40'h0);
    chk("s5_rst_outs", {37'h0, Rx_Done, Frame_Err, Timeout}, 40'h0);
    uart_rx = 1'b1;
    #200;
    Reset_n = 1'b1;
    idle(2);
    clr_mon();
    send_pkt(40'h0E0D0C0B0A, BIT_NS);
    idle(2);
    chk("s5_done", 40'(n_done), 40'd1);
    chk("s5_word", word_at(0), 40'h0E0D0C0B0A);
    chk("s5_errs", 40'(n_ferr + n_to), 40'd0);

    // Baud offset -2% then +2%, one bit time apart
    clr_mon();
    send_pkt(40'h8877665544, BIT_NS / 0.98);
    idle(1);
    send_pkt(40'h13579BDF02, BIT_NS / 1.02);
    idle(2);
    chk("s6_done", 40'(n_done), 40'd2);
    chk("s6_word0", word_at(0), 40'h8877665544);
    chk("s6_word1", word_at(1), 40'h13579BDF02);
    chk("s6_to", 40'(n_to), 40'd0);
    chk("s6_ferr", 40'(n_ferr), 40'd0);

    // Whole-run invariants
    chk("pulse_overlap", 40'(n_overlap), 40'd0);
    chk("data40_stable", 40'(n_d40_chg), 40'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_data40.md
# uart_rx_data40

Receives a 5-byte packet on a UART line and assembles it into one 40-bit word. It is the receive-side counterpart of the 40-bit packet transmitter. Byte 0 arrives first and lands in Data40[7:0]; byte 4 lands in Data40[39:32]. An inter-byte timeout resynchronises the block on lost bytes, and framing errors are flagged and the partial packet is discarded.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: Clk frequency in Hz.
- BAUD, 115200: line bit rate.
- TIMEOUT_BITS, 20: maximum idle gap between bytes of one packet, in bit times.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset: asynchronous, active-low.
- uart_rx  in  1  serial line, idle high, asynchronous to Clk.
- Data40  out  40  last complete packet; holds until the next complete packet.
- Rx_Done  out  1  one-cycle pulse: Data40 was just updated.
- Frame_Err  out  1  one-cycle pulse: stop bit read as 0; partial packet dropped.
- Timeout  out  1  one-cycle pulse: partial packet (1–4 bytes) dropped on gap expiry.

## Operation
- Frame format: 8N1, LSB first.
- Bit clock: 16x oversampling tick, divider OSR_DIV = CLK_FREQ/(BAUD*16), rounded to nearest. Default is 27.
- Input synchroniser: 2 flops on uart_rx before any use.

Byte receiver FSM (sub-module):
- IDLE: a falling edge on the synchronised line moves to START.
- START: at tick 8, majority of ticks 7/8/9 = 1 is a false start; return to IDLE, nothing reported.
- DATA: 8 bits, each the majority of ticks 7/8/9 within its 16-tick bit; shifted in LSB first.
- STOP: at the middle of the stop bit:
  - 1 → pulse byte_done with byte_data.
  - 0 → pulse byte_err.
  - Either way, return to IDLE. Waiting for the line to go high is not required before the next start detection, but a falling edge is.

Packer FSM (top level):
- Byte index cnt (0..4) and a 40-bit shift register.
- On byte_done: write byte into slot cnt, then cnt++.
  - If cnt was 4: copy assembled word to Data40, pulse Rx_Done, cnt←0.
- On byte_err: cnt←0, pulse Frame_Err. Data40 is unchanged.
- Gap timer:
  - Counts Clk cycles while cnt≠0 and the byte receiver is in IDLE.
  - Clears on any start detection.
  - Expiry at TIMEOUT_BITS*16*OSR_DIV cycles → cnt←0, pulse Timeout.
  - Does not run while cnt=0.
- Simultaneous events:
  - Timer expiry and start detection in the same cycle: the start wins; no Timeout.
  - byte_done and byte_err are mutually exclusive by construction.
- Rx_Done, Frame_Err and Timeout are never asserted in the same cycle.

## Timing
- Reset values: Data40=0, Rx_Done=0, Frame_Err=0, Timeout=0. Also cnt=0, byte FSM in IDLE, synchroniser flops=1.
- Reset asserted mid-packet: all state is cleared immediately. After release, the block waits for a fresh falling edge. A byte already in flight is lost, and the packet restarts at byte 0.
- Latency, byte level: byte_done fires at the middle of the stop bit, ~9.5 bit times after the start edge, plus 2–3 Clk for the synchroniser.
- Latency, packet level: Rx_Done and Data40 update on the Clk edge one cycle after the fifth byte_done (registered).
- Data40 changes only in the Rx_Done cycle.
- No back-pressure: the consumer must capture Data40 before the next packet completes. The minimum interval is 5 frame times.

## Structure
- Shared package uart_pkg holds:
  - OSR = 16.
  - Byte FSM state encoding (IDLE, START, DATA, STOP).
  - Functions computing OSR_DIV and the timeout cycle count from the parameters.
- Sub-module uart_byte_rx holds the synchroniser, oversampling divider, byte FSM and majority voter.
  - Ports: Clk, Reset_n, uart_rx, byte_data[7:0], byte_done, byte_err, busy.
  - The top level instantiates it once and contains only the packer FSM and gap timer.

## Test plan
- Send 0x11,0x22,0x33,0x44,0x55 back-to-back at 115200 with 50 MHz Clk → exactly one Rx_Done, Data40=0x5544332211, Frame_Err=Timeout=0.
- Send 3 bytes 0xAA,0xBB,0xCC, idle 25 bit times, then 0x01..0x05 → one Timeout pulse about 20 bit times after byte 3; then Rx_Done with Data40=0x0504030201.
- Send 0x12,0x34, then a byte 0x56 whose stop bit is 0, then 0x01..0x05 → one Frame_Err, then Rx_Done with Data40=0x0504030201.
- Inject a 4-tick low glitch on an idle line, then a valid packet 0xDEADBEEF00 → no pulses for the glitch; Data40=0xDEADBEEF00.
- Assert Reset_n low during the DATA bits of byte 2, release, then send 0x0A..0x0E → all outputs 0 during reset; then Rx_Done with Data40=0x0E0D0C0B0A.
- Send two packets separated by a 1-bit-time gap with BAUD offset ±2% → two Rx_Done pulses with correct words, no Timeout.
